// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and codes for the data-memory SRAM bridge
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;
  localparam logic [1:0] DEN_IDLE = 2'b00;
  localparam logic [1:0] DEN_RD = 2'b01;
  localparam logic [1:0] DEN_WR = 2'b10;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [2:0] KSEG0_HI = 3'b100;
  localparam logic [2:0] KSEG1_HI = 3'b101;
  function automatic logic [1:0] bus_size(input logic [2:0] sz);
    return (sz >= 3'd3) ? SZ_W : sz[1:0];
  endfunction
endpackage

// File: rtl/dmem_addr_map.sv
// dmem_addr_map: kseg0/kseg1 unmapped virtual to physical translation
module dmem_addr_map import dmem_pkg::*; #(
  parameter bit ADDR_MAP_EN = 1'b1
) (
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);
  logic w_unmapped;
  assign w_unmapped = ADDR_MAP_EN && (i_vaddr[31:29] == KSEG0_HI || i_vaddr[31:29] == KSEG1_HI);
  assign o_paddr = w_unmapped ? {3'b000, i_vaddr[28:0]} : i_vaddr;
endmodule

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: runs one SRAM-like bus transaction per memory-stage load/store, stalling the pipe meanwhile
module dmem_sram_bridge import dmem_pkg::*; #(
  parameter bit ADDR_MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  d_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  input  logic [3:0]  w_byte_select,
  input  logic        pipe_hold,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  state_t      r_state, w_next;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic [31:0] w_paddr;
  logic        w_start;

  dmem_addr_map #(.ADDR_MAP_EN(ADDR_MAP_EN)) u_map (
    .i_vaddr(d_addr),
    .o_paddr(w_paddr)
  );

  assign w_start = (r_state == S_IDLE) && (d_en != DEN_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= SZ_B;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_wr    <= d_en != DEN_RD;
        r_size  <= bus_size(d_size);
        r_addr  <= w_paddr;
        r_wdata <= d_wdata;
        r_wstrb <= w_byte_select;
      end
      if (r_state == S_DATA && data_data_ok && !r_wr) r_rdata <= data_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_ADDR : S_IDLE;
      S_ADDR:  w_next = data_addr_ok ? S_DATA : S_ADDR;
      S_DATA:  w_next = data_data_ok ? S_DONE : S_DATA;
      default: w_next = pipe_hold ? S_DONE : S_IDLE;
    endcase
  end

  assign d_stall    = resetn && (w_start || r_state == S_ADDR || r_state == S_DATA);
  assign data_req   = r_state == S_ADDR;
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign data_wstrb = r_wstrb;
  assign d_rdata    = r_rdata;
endmodule

// File: tb/tb_dmem_sram_bridge.sv
// tb_dmem_sram_bridge: scoreboard bench with directed load/store vectors
module tb_dmem_sram_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  d_en;
  logic [31:0] d_addr, d_wdata;
  logic [2:0]  d_size;
  logic [3:0]  w_byte_select;
  logic        pipe_hold;
  logic [31:0] d_rdata;
  logic        d_stall, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] pt_rdata, pt_addr, pt_wdata;
  logic        pt_stall, pt_req, pt_wr;
  logic [1:0]  pt_size;
  logic [3:0]  pt_wstrb;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    int          reqc;
  } bus_t;
  typedef struct {
    logic [31:0] rdata;
    int          stalls;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.ADDR_MAP_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .d_en(d_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .w_byte_select(w_byte_select), .pipe_hold(pipe_hold),
    .d_rdata(d_rdata), .d_stall(d_stall), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  dmem_sram_bridge #(.ADDR_MAP_EN(1'b0)) u_pt (
    .clk(clk), .resetn(resetn), .d_en(d_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .w_byte_select(w_byte_select), .pipe_hold(pipe_hold),
    .d_rdata(pt_rdata), .d_stall(pt_stall), .data_req(pt_req), .data_wr(pt_wr),
    .data_size(pt_size), .data_addr(pt_addr), .data_wdata(pt_wdata),
    .data_wstrb(pt_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    bus_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall_cnt = 0;
        req_cnt = 0;
      end else begin
        if (data_req) begin
          req_cnt++;
          if (exp_bus.size() == 0) chk("spurious_req", {31'd0, data_req}, 32'd0);
          else if (data_addr_ok) begin
            b = exp_bus.pop_front();
            chk("data_addr", data_addr, b.addr);
            chk("pt_data_addr", pt_addr, b.vaddr);
            chk("data_wr", {31'd0, data_wr}, {31'd0, b.wr});
            chk("data_size", {30'd0, data_size}, {30'd0, b.size});
            chk("data_wdata", data_wdata, b.wdata);
            chk("data_wstrb", {28'd0, data_wstrb}, {28'd0, b.strb});
            chk("req_cycles", req_cnt, b.reqc);
            req_cnt = 0;
          end
        end
        if (d_stall) stall_cnt++;
        else if (stall_cnt > 0) begin
          if (exp_rsp.size() == 0) chk("spurious_done", stall_cnt, 32'd0);
          else begin
            r = exp_rsp.pop_front();
            chk("d_rdata", d_rdata, r.rdata);
            chk("stall_cycles", stall_cnt, r.stalls);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic txn(input logic [1:0] en, input logic [31:0] va, input logic [31:0] pa,
                     input logic [2:0] sz, input logic ewr, input logic [1:0] esz,
                     input logic [31:0] wd, input logic [3:0] st, input int a_dly,
                     input int d_dly, input logic [31:0] rd, input int hold);
    bus_t b;
    rsp_t r;
    b.addr = pa; b.vaddr = va; b.wdata = wd; b.wr = ewr; b.size = esz; b.strb = st;
    b.reqc = a_dly + 1;
    exp_bus.push_back(b);
    if (!ewr) model_rdata = rd;
    r.rdata = model_rdata;
    r.stalls = 3 + a_dly + d_dly;
    exp_rsp.push_back(r);
    d_en = en; d_addr = va; d_size = sz; d_wdata = wd; w_byte_select = st;
    @(posedge clk) #1;
    repeat (a_dly) @(posedge clk) #1;
    data_addr_ok = 1'b1;
    @(posedge clk) #1;
    data_addr_ok = 1'b0;
    repeat (d_dly) @(posedge clk) #1;
    data_data_ok = 1'b1;
    data_rdata = rd;
    @(posedge clk) #1;
    data_data_ok = 1'b0;
    data_rdata = 32'h0BAD_0BAD;
    if (hold > 0) begin
      pipe_hold = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_stall", {31'd0, d_stall}, 32'd0);
        chk("hold_rdata", d_rdata, model_rdata);
        @(posedge clk) #1;
      end
      pipe_hold = 1'b0;
    end
    d_en = 2'b00;
    @(posedge clk) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; d_en = 2'b01; d_addr = 32'h8000_0000; d_wdata = '0; d_size = 3'd2;
    w_byte_select = '0; pipe_hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = '0; model_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, d_stall}, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_rdata", d_rdata, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wr_size_strb", {25'd0, data_wr, data_size, data_wstrb}, 32'd0);
    @(posedge clk) #1;
    resetn = 1'b1; d_en = 2'b00;
    @(posedge clk) #1;
    txn(2'b01, 32'h8000_0010, 32'h0000_0010, 3'd2, 1'b0, 2'd2, 32'h0, 4'b0000, 0, 0, 32'hDEAD_BEEF, 0);
    txn(2'b10, 32'h0040_0000, 32'h0040_0000, 3'd0, 1'b1, 2'd0, 32'h00AB_0000, 4'b0100, 2, 1, 32'h0, 0);
    txn(2'b01, 32'hA000_1234, 32'h0000_1234, 3'd1, 1'b0, 2'd1, 32'h0, 4'b0011, 1, 2, 32'h0000_CAFE, 4);
    begin : reset_mid
      bus_t b;
      b.addr = 32'h0000_0100; b.vaddr = 32'h8000_0100; b.wdata = 32'h0; b.wr = 1'b0;
      b.size = 2'd2; b.strb = 4'b0000; b.reqc = 1;
      exp_bus.push_back(b);
      d_en = 2'b01; d_addr = 32'h8000_0100; d_size = 3'd2; d_wdata = '0; w_byte_select = '0;
      @(posedge clk) #1;
      data_addr_ok = 1'b1;
      @(posedge clk) #1;
      data_addr_ok = 1'b0;
      resetn = 1'b0; d_en = 2'b00;
      @(negedge clk);
      chk("rstmid_stall", {31'd0, d_stall}, 32'd0);
      @(posedge clk) #1;
      resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
      model_rdata = '0;
      @(negedge clk);
      chk("rstmid_rdata", d_rdata, 32'd0);
      chk("rstmid_addr", data_addr, 32'd0);
      chk("rstmid_req_stall", {30'd0, data_req, d_stall}, 32'd0);
      @(posedge clk) #1;
      data_data_ok = 1'b0;
      @(negedge clk);
      chk("late_ok_rdata", d_rdata, 32'd0);
      chk("late_ok_req", {31'd0, data_req}, 32'd0);
      @(posedge clk) #1;
    end
    txn(2'b01, 32'hBFC0_0000, 32'h1FC0_0000, 3'd2, 1'b0, 2'd2, 32'h0, 4'b0000, 0, 0, 32'h1122_3344, 0);
    txn(2'b11, 32'hC000_0008, 32'hC000_0008, 3'd7, 1'b1, 2'd2, 32'h55AA_55AA, 4'b1111, 0, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_q_empty", exp_bus.size(), 32'd0);
    chk("rsp_q_empty", exp_rsp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
